// File: rtl/mac_stream_pkg.sv
// Shared definitions for the streaming MAC: defaults, state encoding, widening helper.
package mac_stream_pkg;

  localparam int DATA_W_DEF = 8;
  localparam int ACC_W_DEF  = 20;
  localparam int LEN_W_DEF  = 5;

  // Widest accumulator the widening helper can produce (ACC_W must stay below this).
  localparam int WIDEN_MAX  = 64;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  // Sign- or zero-extend the low prod_w bits of prod to WIDEN_MAX bits.
  function automatic logic [WIDEN_MAX-1:0] widen(input logic [WIDEN_MAX-1:0] prod,
                                                 input int prod_w,
                                                 input logic sgn);
    logic [WIDEN_MAX-1:0] mask;
    logic [WIDEN_MAX-1:0] msb_mask;
    logic                 fill;
    mask     = {WIDEN_MAX{1'b1}} >> (WIDEN_MAX - prod_w);
    msb_mask = mask & ~(mask >> 1);
    fill     = sgn & (|(prod & msb_mask));
    return fill ? (prod | ~mask) : (prod & mask);
  endfunction

endpackage

// File: rtl/mac_stream_acc.sv
// Product register, product widening, accumulator adder and sticky overflow detect.
module mac_stream_acc
  import mac_stream_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ACC_W  = ACC_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear_i,
  input  logic              load_i,
  input  logic              signed_i,
  input  logic [DATA_W-1:0] a_i,
  input  logic [DATA_W-1:0] b_i,
  output logic [ACC_W-1:0]  acc_o,
  output logic              ovf_o,
  output logic              pv_o
);

  localparam int PROD_W = 2 * DATA_W;

  logic [PROD_W-1:0]        prod_q, prod_d;
  logic                     pv_q, pv_d;
  logic [ACC_W-1:0]         acc_q, acc_d;
  logic                     ovf_q, ovf_d;
  logic signed [PROD_W-1:0] prod_s;
  logic [PROD_W-1:0]        prod_u;
  logic [WIDEN_MAX-1:0]     wide;
  logic [ACC_W-1:0]         addend;
  logic [ACC_W:0]           sum;
  logic                     ovf_now;
  logic                     unused_hi;

  assign prod_s    = PROD_W'($signed(a_i)) * PROD_W'($signed(b_i));
  assign prod_u    = PROD_W'(a_i) * PROD_W'(b_i);
  assign wide      = widen(WIDEN_MAX'(prod_q), PROD_W, signed_i);
  assign addend    = wide[ACC_W-1:0];
  assign unused_hi = ^wide[WIDEN_MAX-1:ACC_W];
  assign sum       = {1'b0, acc_q} + {1'b0, addend};
  // Signed: like-signed addends whose sum flips sign. Unsigned: carry out of the top bit.
  assign ovf_now   = signed_i ? ((acc_q[ACC_W-1] == addend[ACC_W-1]) &&
                                 (sum[ACC_W-1] != acc_q[ACC_W-1]))
                              : sum[ACC_W];

  // Next state: capture a product on accept, fold the held product in; clear wins.
  always_comb begin
    prod_d = prod_q;
    pv_d   = 1'b0;
    acc_d  = acc_q;
    ovf_d  = ovf_q;
    if (load_i) begin
      prod_d = signed_i ? prod_s : prod_u;
      pv_d   = 1'b1;
    end
    if (pv_q) begin
      acc_d = sum[ACC_W-1:0];
      ovf_d = ovf_q | ovf_now;
    end
    if (clear_i) begin
      prod_d = '0;
      pv_d   = 1'b0;
      acc_d  = '0;
      ovf_d  = 1'b0;
    end
  end

  // Datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prod_q <= '0;
      pv_q   <= 1'b0;
      acc_q  <= '0;
      ovf_q  <= 1'b0;
    end else begin
      prod_q <= prod_d;
      pv_q   <= pv_d;
      acc_q  <= acc_d;
      ovf_q  <= ovf_d;
    end
  end

  assign acc_o = acc_q;
  assign ovf_o = ovf_q;
  assign pv_o  = pv_q;

endmodule

// File: rtl/mac_stream.sv
// Streaming multiply-accumulate engine: job FSM, pair counter and handshakes.
module mac_stream
  import mac_stream_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ACC_W  = ACC_W_DEF,   // >= 2*DATA_W and < WIDEN_MAX
  parameter int LEN_W  = LEN_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [LEN_W-1:0]  len,
  input  logic              signed_mode,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ACC_W-1:0]  result,
  output logic              overflow,
  output logic              busy
);

  state_e           state_q, state_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [LEN_W-1:0] cnt_q, cnt_d;
  logic             sgn_q, sgn_d;
  logic             job_start;
  logic             accept;
  logic             last_accept;
  logic             pv;

  assign job_start   = (state_q == ST_IDLE) && start;
  assign accept      = in_valid && in_ready;
  assign last_accept = accept && ((cnt_q + LEN_W'(1)) == len_q);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Next-state: DRAIN waits one cycle for the final product to be added.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (start) state_d = (len == '0) ? ST_DONE : ST_RUN;
      ST_RUN:   if (last_accept) state_d = ST_DRAIN;
      ST_DRAIN: if (pv) state_d = ST_DONE;
      ST_DONE:  if (out_ready) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Handshake and status outputs decoded from state.
  always_comb begin
    in_ready  = (state_q == ST_RUN);
    out_valid = (state_q == ST_DONE);
    busy      = (state_q != ST_IDLE);
  end

  // Job parameters latch on start; count advances per accepted pair.
  always_comb begin
    len_d = len_q;
    sgn_d = sgn_q;
    cnt_d = cnt_q;
    if (job_start) begin
      len_d = len;
      sgn_d = signed_mode;
      cnt_d = '0;
    end else if (accept) begin
      cnt_d = cnt_q + LEN_W'(1);
    end
  end

  // Job parameter and counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      len_q <= '0;
      sgn_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      len_q <= len_d;
      sgn_q <= sgn_d;
      cnt_q <= cnt_d;
    end
  end

  mac_stream_acc #(
    .DATA_W (DATA_W),
    .ACC_W  (ACC_W)
  ) u_acc (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear_i  (job_start),
    .load_i   (accept),
    .signed_i (sgn_q),
    .a_i      (a),
    .b_i      (b),
    .acc_o    (result),
    .ovf_o    (overflow),
    .pv_o     (pv)
  );

endmodule

// File: tb/tb_mac_stream.sv
// Randomised + directed bench for mac_stream against an arithmetic job model.
module tb_mac_stream;

  localparam int DATA_W = 8;
  localparam int ACC_W  = 20;
  localparam int LEN_W  = 5;
  localparam longint MOD  = longint'(1) << ACC_W;
  localparam longint SMAX = (longint'(1) << (ACC_W - 1)) - 1;
  localparam longint SMIN = -(longint'(1) << (ACC_W - 1));

  logic              clk = 1'b0;
  logic              rst_n;
  logic              start;
  logic [LEN_W-1:0]  len;
  logic              signed_mode;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] a, b;
  logic              out_valid;
  logic              out_ready;
  logic [ACC_W-1:0]  result;
  logic              overflow;
  logic              busy;

  int     vec  = 0;
  int     miss = 0;
  bit     exp_on = 1'b0;
  longint exp_res;
  bit     exp_ovf;
  logic [DATA_W-1:0] pa [32];
  logic [DATA_W-1:0] pb [32];

  always #5 clk = ~clk;

  mac_stream #(.DATA_W(DATA_W), .ACC_W(ACC_W), .LEN_W(LEN_W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .len(len), .signed_mode(signed_mode),
    .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b),
    .out_valid(out_valid), .out_ready(out_ready), .result(result),
    .overflow(overflow), .busy(busy)
  );

  task automatic chk(input string name, input longint act, input longint exp);
    vec++;
    if (act != exp) begin
      miss++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Job model: plain integer sum of products, wrapped to ACC_W, with overflow
  // judged by whether each true partial sum falls outside the representable range.
  function automatic void model(input int n, input bit sgn, output longint r, output bit o);
    longint acc = 0;
    longint p, t, s;
    o = 1'b0;
    for (int i = 0; i < n; i++) begin
      if (sgn) p = longint'($signed(pa[i])) * longint'($signed(pb[i]));
      else     p = longint'(pa[i]) * longint'(pb[i]);
      if (sgn) begin
        s = (acc > SMAX) ? acc - MOD : acc;
        t = s + p;
        if (t > SMAX || t < SMIN) o = 1'b1;
      end else begin
        t = acc + p;
        if (t >= MOD) o = 1'b1;
      end
      acc = ((t % MOD) + MOD) % MOD;
    end
    r = acc;
  endfunction

  // Continuous check of the held result whenever the DUT presents one.
  always @(negedge clk) begin
    if (rst_n && exp_on && out_valid) begin
      chk("result", longint'(result), exp_res);
      chk("overflow", longint'(overflow), longint'(exp_ovf));
    end
  end

  // Runs one job from IDLE; returns what the DUT presented with out_valid.
  task automatic run_job(input int n, input bit sgn, input int gap_pct, input int hold,
                         input bit pulse_start, output longint r_got, output bit o_got);
    int i = 0;
    int guard = 0;
    bit took;
    model(n, sgn, exp_res, exp_ovf);
    exp_on = 1'b1;
    start = 1'b1; len = LEN_W'(n); signed_mode = sgn;
    @(posedge clk); #1;
    start = 1'b0;
    if (n == 0) begin
      chk("len0_valid", longint'(out_valid), 1);
      chk("len0_in_ready", longint'(in_ready), 0);
    end else begin
      while (i < n && guard < 500) begin
        guard++;
        in_valid = ($urandom_range(0, 99) >= gap_pct);
        a = pa[i]; b = pb[i];
        chk("in_ready_run", longint'(in_ready), 1);
        took = in_valid && in_ready;
        @(posedge clk); #1;
        if (took) i++;
      end
      in_valid = 1'b0;
      chk("accept_count", i, n);
      chk("in_ready_drop", longint'(in_ready), 0);
      chk("valid_early", longint'(out_valid), 0);
      @(posedge clk); #1;
      chk("valid_latency", longint'(out_valid), 1);
    end
    r_got = longint'(result);
    o_got = overflow;
    for (int k = 0; k < hold; k++) begin
      start = pulse_start && (k == 0);
      if (start) len = LEN_W'(5);
      @(posedge clk); #1;
      chk("hold_valid", longint'(out_valid), 1);
      chk("hold_busy", longint'(busy), 1);
    end
    start = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("taken_valid", longint'(out_valid), 0);
    chk("taken_busy", longint'(busy), 0);
    exp_on = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    longint r;
    bit     o;
    rst_n = 1'b0; start = 1'b0; len = '0; signed_mode = 1'b0;
    in_valid = 1'b0; a = '0; b = '0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", longint'(busy), 0);
    chk("rst_in_ready", longint'(in_ready), 0);
    chk("rst_out_valid", longint'(out_valid), 0);
    chk("rst_result", longint'(result), 0);
    chk("rst_overflow", longint'(overflow), 0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    // Unsigned back-to-back.
    pa[0] = 8'd2; pb[0] = 8'd3; pa[1] = 8'd4; pb[1] = 8'd5; pa[2] = 8'd255; pb[2] = 8'd255;
    run_job(3, 1'b0, 0, 0, 1'b0, r, o);
    chk("t1_result", r, 65051);
    chk("t1_ovf", longint'(o), 0);

    // Signed.
    pa[0] = 8'h80; pb[0] = 8'h80; pa[1] = 8'hFF; pb[1] = 8'h01;
    run_job(2, 1'b1, 0, 0, 1'b0, r, o);
    chk("t2_result", r, 16383);
    chk("t2_ovf", longint'(o), 0);

    // Unsigned wrap with overflow.
    for (int i = 0; i < 17; i++) begin pa[i] = 8'd255; pb[i] = 8'd255; end
    run_job(17, 1'b0, 0, 0, 1'b0, r, o);
    chk("t3_result", r, 56849);
    chk("t3_ovf", longint'(o), 1);

    // Zero-length job.
    run_job(0, 1'b0, 0, 1, 1'b0, r, o);
    chk("t4_result", r, 0);

    // Input gaps, held result, start ignored in DONE.
    for (int i = 0; i < 4; i++) begin pa[i] = 8'd1; pb[i] = 8'd1; end
    run_job(4, 1'b0, 50, 5, 1'b1, r, o);
    chk("t5_result", r, 4);

    // Reset mid-run after two of four pairs.
    for (int i = 0; i < 4; i++) begin pa[i] = 8'd1; pb[i] = 8'd1; end
    start = 1'b1; len = LEN_W'(4); signed_mode = 1'b0;
    @(posedge clk); #1;
    start = 1'b0; in_valid = 1'b1; a = 8'd1; b = 8'd1;
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    in_valid = 1'b0;
    chk("mid_rst_busy", longint'(busy), 0);
    chk("mid_rst_in_ready", longint'(in_ready), 0);
    chk("mid_rst_out_valid", longint'(out_valid), 0);
    chk("mid_rst_result", longint'(result), 0);
    chk("mid_rst_overflow", longint'(overflow), 0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    pa[0] = 8'd3; pb[0] = 8'd3; pa[1] = 8'd3; pb[1] = 8'd3;
    run_job(2, 1'b0, 0, 0, 1'b0, r, o);
    chk("t6_result", r, 18);

    // Randomised jobs.
    for (int j = 0; j < 16; j++) begin
      int n;
      n = $urandom_range(0, 31);
      for (int i = 0; i < 32; i++) begin
        pa[i] = DATA_W'($urandom);
        pb[i] = DATA_W'($urandom);
      end
      run_job(n, 1'($urandom_range(0, 1)), $urandom_range(0, 40),
              $urandom_range(0, 4), 1'($urandom_range(0, 1)), r, o);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end

endmodule

// File: doc/mac_stream.md
Name: mac_stream

Overview:
- Parametrised streaming multiply-accumulate engine; next generation of the fixed 8-bit, 16-entry MAC.
- Accepts operand pairs over a valid/ready handshake, with a run length programmable per job.
- Supports signed and unsigned modes, a sticky overflow flag, and a held result with an output handshake.
- Sits between an operand fetch/FIFO stage and a result consumer in the datapath.

Parameters:
- DATA_W, 8: operand width in bits.
- ACC_W, 20: accumulator and result width in bits; must be at least 2*DATA_W.
- LEN_W, 5: width of the job length field; maximum job length is 2^LEN_W-1 pairs.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle job start; honoured only in IDLE.
- len  in  LEN_W  number of pairs in the job; sampled with start.
- signed_mode  in  1  1 = two's-complement operands; sampled with start.
- in_valid  in  1  operand pair valid.
- in_ready  out  1  engine can accept a pair.
- a  in  DATA_W  operand A.
- b  in  DATA_W  operand B.
- out_valid  out  1  result valid; held until taken.
- out_ready  in  1  consumer takes the result.
- result  out  ACC_W  accumulated sum.
- overflow  out  1  sticky per job; qualified with out_valid.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset values (async, on rst_n low): state IDLE; accumulator, count, product register, result and overflow all 0; in_ready, out_valid and busy all 0.
- States: IDLE, RUN, DRAIN, DONE.
- IDLE, start=1:
  - Latch len and signed_mode; clear accumulator, count, overflow and product-valid.
  - If len=0, go to DONE with result 0; otherwise go to RUN.
- IDLE, start=0: stay in IDLE. start is ignored in every other state.
- RUN:
  - in_ready = 1.
  - An accept (in_valid && in_ready) registers a*b into the product register, with product-valid set, and increments count.
  - Product width is 2*DATA_W, signed or unsigned per the latched mode.
  - When the accept brings count to len, go to DRAIN; in_ready drops from the next cycle.
- Accumulate stage:
  - Every cycle product-valid is set, add the product to the accumulator: sign-extended in signed mode, zero-extended in unsigned mode.
  - Clear product-valid if no new accept occurs that cycle.
  - Throughput is one pair per clock.
- DRAIN: once the final product has been added, go to DONE.
- Latency: last accept at edge E; accumulate at edge E+1; DONE and out_valid from E+1.
- DONE:
  - out_valid = 1; result = accumulator, held stable.
  - On out_valid && out_ready, return to IDLE and drop out_valid next cycle.
- Overflow, sticky until the next start:
  - Unsigned mode: carry out of bit ACC_W-1.
  - Signed mode: both addends share a sign and the sum's sign differs.
  - Result wraps modulo 2^ACC_W; no saturation.
- Backpressure: in_valid low during RUN stalls with no state change. out_ready low in DONE holds result indefinitely.
- Reset mid-job: all state returns to reset values immediately, and the partial sum is discarded.

Decomposition:
- Shared package holds:
  - state encoding constants (IDLE, RUN, DRAIN, DONE);
  - DATA_W/ACC_W/LEN_W defaults;
  - a widening helper: sign- or zero-extend a 2*DATA_W product to ACC_W.
- One sub-module, mac_stream_acc: product register, extension, accumulator adder and overflow detect.
- FSM, counter and handshakes live in the top module.

Test Plan:
- Unsigned, len=3, pairs (2,3),(4,5),(255,255) back-to-back -> result=65051, overflow=0, out_valid two cycles after the last accept.
- Signed, len=2, pairs (-128,-128),(-1,1) -> result=16383, overflow=0.
- Unsigned, len=17, all pairs (255,255) -> overflow=1, result=56849.
- len=0 with start -> DONE on the next cycle, result=0; no pairs accepted (in_ready stays 0).
- Backpressure: in_valid gaps during len=4 of (1,1) -> result=4; out_ready held low for 5 cycles -> result stable; start pulsed in DONE is ignored.
- Reset: rst_n asserted mid-RUN after 2 of 4 pairs -> all outputs 0 immediately; a fresh job of (3,3),(3,3) -> result=18.
